// File: rtl/core_if_pkg.sv
// Shared core-interface constants: BRAM slot indices and the CPU memory map.
package core_if_pkg;

    localparam int unsigned BRAM_PROG_ROM = 0;
    localparam int unsigned BRAM_PROG_RAM = 1;
    localparam int unsigned BRAM_VECTOR   = 2;
    localparam int unsigned BRAM_MATH     = 3;
    localparam int unsigned BRAM_POKEY    = 4;
    localparam int unsigned NUM_SLOTS     = 5;

    // Read source latched on a CPU read; slot values match the BRAM indices.
    typedef enum logic [2:0] {
        SelProgRom = 3'd0,
        SelProgRam = 3'd1,
        SelVector  = 3'd2,
        SelMath    = 3'd3,
        SelPokey   = 3'd4,
        SelIo      = 3'd5,
        SelNone    = 3'd6
    } rd_sel_e;

    localparam logic [15:0] PROG_RAM_LO  = 16'h0000;
    localparam logic [15:0] PROG_RAM_HI  = 16'h03FF;
    localparam logic [15:0] IN0_ADDR     = 16'h0800;
    localparam logic [15:0] DSW0_ADDR    = 16'h0A00;
    localparam logic [15:0] DSW1_ADDR    = 16'h0C00;
    localparam logic [15:0] VGGO_ADDR    = 16'h1200;
    localparam logic [15:0] VGRST_ADDR   = 16'h1600;
    localparam logic [15:0] MATH_RD_LO   = 16'h1800;
    localparam logic [15:0] MATH_RD_HI   = 16'h181F;
    localparam logic [15:0] POKEY_LO     = 16'h1820;
    localparam logic [15:0] POKEY_HI     = 16'h182F;
    localparam logic [15:0] SOUND_ADDR   = 16'h1840;
    localparam logic [15:0] MATH_WR_LO   = 16'h1860;
    localparam logic [15:0] MATH_WR_HI   = 16'h187F;
    localparam logic [15:0] VEC_RAM_LO   = 16'h2000;
    localparam logic [15:0] VEC_RAM_HI   = 16'h2FFF;
    localparam logic [15:0] VEC_ROM_HI   = 16'h3FFF;
    localparam logic [15:0] PROG_ROM_LO  = 16'h5000;
    localparam logic [15:0] PROG_ROM_HI  = 16'h7FFF;

    function automatic logic in_range(input logic [15:0] a, input logic [15:0] lo,
                                      input logic [15:0] hi);
        return (a >= lo) && (a <= hi);
    endfunction

endpackage

// File: rtl/addr_decoder.sv
// 6502 address decoder and bus mux: routes CPU accesses to the five memory slots and
// decodes the memory-mapped IO (IN0, DIP switches, vector generator strobes).
module addr_decoder
    import core_if_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clk_en,
    input  logic [15:0]                 addr,
    input  logic [7:0]                  dataFromCore,
    input  logic                        we,
    input  logic [NUM_SLOTS-1:0][7:0]   dataFromBram,
    input  logic                        halt,
    input  logic                        clk_3KHz,
    input  logic                        self_test,
    input  logic [15:0]                 option_switch,
    input  logic                        coin,
    output logic [7:0]                  dataToCore,
    output logic [NUM_SLOTS-1:0][15:0]  addrToBram,
    output logic [NUM_SLOTS-1:0][7:0]   dataToBram,
    output logic [NUM_SLOTS-1:0]        weEnBram,
    output logic                        vggo,
    output logic                        vgrst
);

    rd_sel_e              rd_sel;
    rd_sel_e              sel_q;
    logic [7:0]           io_val;
    logic [7:0]           io_q;
    logic [7:0]           in0;
    logic [NUM_SLOTS-1:0] wr_sel;

    // Slots see the raw CPU address and subtract their own base.
    assign addrToBram = {NUM_SLOTS{addr}};
    assign dataToBram = {NUM_SLOTS{dataFromCore}};

    assign in0 = {clk_3KHz, halt, 1'b1, self_test, 3'b111, ~coin};

    always_comb begin
        rd_sel = SelNone;
        io_val = 8'hFF;
        wr_sel = '0;
        if (in_range(addr, PROG_RAM_LO, PROG_RAM_HI)) begin
            rd_sel                = SelProgRam;
            wr_sel[BRAM_PROG_RAM] = 1'b1;
        end else if (addr == IN0_ADDR) begin
            rd_sel = SelIo;
            io_val = in0;
        end else if (addr == DSW0_ADDR) begin
            rd_sel = SelIo;
            io_val = option_switch[7:0];
        end else if (addr == DSW1_ADDR) begin
            rd_sel = SelIo;
            io_val = option_switch[15:8];
        end else if (in_range(addr, MATH_RD_LO, MATH_RD_HI)) begin
            rd_sel = SelMath;
        end else if (in_range(addr, POKEY_LO, POKEY_HI)) begin
            rd_sel             = SelPokey;
            wr_sel[BRAM_POKEY] = 1'b1;
        end else if (addr == SOUND_ADDR) begin
            wr_sel[BRAM_POKEY] = 1'b1;
        end else if (in_range(addr, MATH_WR_LO, MATH_WR_HI)) begin
            wr_sel[BRAM_MATH] = 1'b1;
        end else if (in_range(addr, VEC_RAM_LO, VEC_RAM_HI)) begin
            rd_sel              = SelVector;
            wr_sel[BRAM_VECTOR] = 1'b1;
        end else if (in_range(addr, VEC_RAM_HI + 16'd1, VEC_ROM_HI)) begin
            rd_sel = SelVector;
        end else if (in_range(addr, PROG_ROM_LO, PROG_ROM_HI)) begin
            rd_sel = SelProgRom;
        end
    end

    assign weEnBram = we ? wr_sel : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_q <= SelNone;
            io_q  <= 8'hFF;
            vggo  <= 1'b0;
            vgrst <= 1'b0;
        end else begin
            vggo  <= clk_en && we && (addr == VGGO_ADDR);
            vgrst <= clk_en && we && (addr == VGRST_ADDR);
            // Slots register their data on the same enable, so latch the source alongside.
            if (clk_en && !we) begin
                sel_q <= rd_sel;
                io_q  <= io_val;
            end
        end
    end

    always_comb begin
        dataToCore = 8'hFF;
        case (sel_q)
            SelProgRom, SelProgRam, SelVector, SelMath, SelPokey:
                dataToCore = dataFromBram[sel_q];
            SelIo:
                dataToCore = io_q;
            default:
                dataToCore = 8'hFF;
        endcase
    end

endmodule

// File: tb/tb_addr_decoder.sv
// Bench for addr_decoder: directed vector table, reset-abort sequence, then random
// accesses checked against a memory-map reference model.
module tb_addr_decoder;

    logic             clk = 1'b0;
    logic             rst;
    logic             clk_en;
    logic [15:0]      addr;
    logic [7:0]       dataFromCore;
    logic             we;
    logic [4:0][7:0]  dataFromBram;
    logic             halt;
    logic             clk_3KHz;
    logic             self_test;
    logic [15:0]      option_switch;
    logic             coin;
    logic [7:0]       dataToCore;
    logic [4:0][15:0] addrToBram;
    logic [4:0][7:0]  dataToBram;
    logic [4:0]       weEnBram;
    logic             vggo;
    logic             vgrst;

    always #5 clk = ~clk;

    addr_decoder dut (
        .clk           (clk),
        .rst           (rst),
        .clk_en        (clk_en),
        .addr          (addr),
        .dataFromCore  (dataFromCore),
        .we            (we),
        .dataFromBram  (dataFromBram),
        .halt          (halt),
        .clk_3KHz      (clk_3KHz),
        .self_test     (self_test),
        .option_switch (option_switch),
        .coin          (coin),
        .dataToCore    (dataToCore),
        .addrToBram    (addrToBram),
        .dataToBram    (dataToBram),
        .weEnBram      (weEnBram),
        .vggo          (vggo),
        .vgrst         (vgrst)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (addr=%h)", name, act, exp, addr);
        end
    endtask

    typedef struct {
        logic [15:0] a;
        logic        w;
        logic        ce;
        logic [7:0]  din;
        logic [7:0]  exp_rd;
        logic [4:0]  exp_we;
        logic        exp_go;
        logic        exp_rst;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [15:0] a, input logic w, input logic ce,
                                input logic [7:0] din, input logic [7:0] rd,
                                input logic [4:0] wen, input logic go, input logic vr);
        vec_t v;
        v.a = a; v.w = w; v.ce = ce; v.din = din;
        v.exp_rd = rd; v.exp_we = wen; v.exp_go = go; v.exp_rst = vr;
        return v;
    endfunction

    // Reference model: read code 0..4 = slot, 10..12 = IN0/DSW0/DSW1, -1 = unmapped.
    function automatic int rd_code(input logic [15:0] a);
        int x = int'(a);
        if (x <= 'h03FF) return 1;
        if (x == 'h0800) return 10;
        if (x == 'h0A00) return 11;
        if (x == 'h0C00) return 12;
        if (x >= 'h1800 && x < 'h1820) return 3;
        if (x >= 'h1820 && x < 'h1830) return 4;
        if (x >= 'h2000 && x < 'h4000) return 2;
        if (x >= 'h5000 && x < 'h8000) return 0;
        return -1;
    endfunction

    function automatic int wr_slot(input logic [15:0] a);
        int x = int'(a);
        if (x <= 'h03FF) return 1;
        if (x >= 'h1820 && x < 'h1830) return 4;
        if (x == 'h1840) return 4;
        if (x >= 'h1860 && x < 'h1880) return 3;
        if (x >= 'h2000 && x < 'h3000) return 2;
        return -1;
    endfunction

    function automatic int io_value(input int code);
        if (code == 10)
            return (int'(clk_3KHz) * 128) + (int'(halt) * 64) + 32 + (int'(self_test) * 16)
                   + 14 + (coin ? 0 : 1);
        if (code == 11) return int'(option_switch) % 256;
        return int'(option_switch) / 256;
    endfunction

    task automatic drive(input logic [15:0] a, input logic w, input logic ce,
                         input logic [7:0] din);
        @(negedge clk);
        addr = a; we = w; clk_en = ce; dataFromCore = din;
        #1;
    endtask

    task automatic check_bus(input string tag);
        for (int i = 0; i < 5; i++) begin
            check({tag, " addrToBram"}, 32'(addrToBram[i]), 32'(addr));
            check({tag, " dataToBram"}, 32'(dataToBram[i]), 32'(dataFromCore));
        end
    endtask

    int         exp_kind;
    int         exp_io;
    int         code;
    int         ws;
    logic [4:0] ewe;
    logic       exp_go;
    logic       exp_vr;
    logic [7:0] exp_rd;
    logic [15:0] bases [16] = '{16'h0000, 16'h0800, 16'h0A00, 16'h0C00, 16'h1200, 16'h1400,
                                16'h1600, 16'h1800, 16'h1820, 16'h1840, 16'h1860, 16'h2000,
                                16'h3000, 16'h4000, 16'h5000, 16'h7FF0};

    initial begin
        rst = 1'b1; clk_en = 1'b0; we = 1'b0; addr = 16'h0; dataFromCore = 8'h0;
        dataFromBram = {8'h44, 8'h33, 8'h22, 8'h11, 8'hA5};
        halt = 1'b0; clk_3KHz = 1'b1; self_test = 1'b1; coin = 1'b1;
        option_switch = 16'h1234;

        repeat (2) @(posedge clk);
        #1;
        check("reset dataToCore", 32'(dataToCore), 32'hFF);
        check("reset vggo", 32'(vggo), 32'h0);
        check("reset vgrst", 32'(vgrst), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        vecs.push_back(mk(16'h5123, 0, 1, 8'h00, 8'hA5, 5'b00000, 0, 0));
        vecs.push_back(mk(16'h0021, 1, 1, 8'h55, 8'hA5, 5'b00010, 0, 0));
        vecs.push_back(mk(16'h3010, 1, 1, 8'h66, 8'hA5, 5'b00000, 0, 0));
        vecs.push_back(mk(16'h1200, 1, 1, 8'h00, 8'hA5, 5'b00000, 1, 0));
        vecs.push_back(mk(16'h1600, 1, 1, 8'h00, 8'hA5, 5'b00000, 0, 1));
        vecs.push_back(mk(16'h1400, 1, 1, 8'h00, 8'hA5, 5'b00000, 0, 0));
        vecs.push_back(mk(16'h1200, 1, 0, 8'h00, 8'hA5, 5'b00000, 0, 0));
        vecs.push_back(mk(16'h0800, 0, 1, 8'h00, 8'hBE, 5'b00000, 0, 0));
        vecs.push_back(mk(16'h0A00, 0, 1, 8'h00, 8'h34, 5'b00000, 0, 0));
        vecs.push_back(mk(16'h0C00, 0, 1, 8'h00, 8'h12, 5'b00000, 0, 0));
        vecs.push_back(mk(16'h0500, 0, 1, 8'h00, 8'hFF, 5'b00000, 0, 0));
        vecs.push_back(mk(16'h1840, 1, 1, 8'h77, 8'hFF, 5'b10000, 0, 0));
        vecs.push_back(mk(16'h1820, 0, 1, 8'h00, 8'h44, 5'b00000, 0, 0));
        vecs.push_back(mk(16'h1800, 0, 1, 8'h00, 8'h33, 5'b00000, 0, 0));
        vecs.push_back(mk(16'h1860, 1, 1, 8'h88, 8'h33, 5'b01000, 0, 0));
        vecs.push_back(mk(16'h1840, 0, 1, 8'h00, 8'hFF, 5'b00000, 0, 0));
        vecs.push_back(mk(16'h2000, 0, 1, 8'h00, 8'h22, 5'b00000, 0, 0));
        vecs.push_back(mk(16'h2FFF, 1, 1, 8'h99, 8'h22, 5'b00100, 0, 0));
        vecs.push_back(mk(16'h0300, 0, 1, 8'h00, 8'h11, 5'b00000, 0, 0));
        vecs.push_back(mk(16'h5000, 0, 0, 8'h00, 8'h11, 5'b00000, 0, 0));
        vecs.push_back(mk(16'h4000, 0, 1, 8'h00, 8'hFF, 5'b00000, 0, 0));
        vecs.push_back(mk(16'h3FFF, 0, 1, 8'h00, 8'h22, 5'b00000, 0, 0));
        vecs.push_back(mk(16'h1820, 1, 1, 8'hAB, 8'h22, 5'b10000, 0, 0));

        foreach (vecs[i]) begin
            drive(vecs[i].a, vecs[i].w, vecs[i].ce, vecs[i].din);
            check("vec weEnBram", 32'(weEnBram), 32'(vecs[i].exp_we));
            check_bus("vec");
            @(posedge clk);
            #1;
            check("vec dataToCore", 32'(dataToCore), 32'(vecs[i].exp_rd));
            check("vec vggo", 32'(vggo), 32'(vecs[i].exp_go));
            check("vec vgrst", 32'(vgrst), 32'(vecs[i].exp_rst));
        end

        // Reset arriving while a vggo strobe is high must kill it and the read path at once.
        drive(16'h5123, 0, 1, 8'h00);
        @(posedge clk);
        drive(16'h1200, 1, 1, 8'h00);
        @(posedge clk);
        #1;
        check("pre-reset vggo", 32'(vggo), 32'h1);
        check("pre-reset dataToCore", 32'(dataToCore), 32'hA5);
        rst = 1'b1;
        #1;
        check("mid-reset vggo", 32'(vggo), 32'h0);
        check("mid-reset dataToCore", 32'(dataToCore), 32'hFF);
        @(negedge clk);
        rst = 1'b0;
        drive(16'h0000, 0, 0, 8'h00);
        @(posedge clk);
        #1;
        check("post-reset dataToCore", 32'(dataToCore), 32'hFF);
        check("post-reset vggo", 32'(vggo), 32'h0);

        exp_kind = -1;
        exp_io   = 255;
        for (int n = 0; n < 400; n++) begin
            logic [15:0] a;
            logic        w;
            logic        ce;
            if ($urandom_range(0, 3) == 0) a = 16'($urandom()) & 16'h7FFF;
            else a = bases[$urandom_range(0, 15)] + 16'($urandom_range(0, 15)) * 16'(n % 2);
            w  = 1'($urandom_range(0, 1));
            ce = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            dataFromBram  = {8'($urandom()), 8'($urandom()), 8'($urandom()),
                             8'($urandom()), 8'($urandom())};
            halt          = 1'($urandom());
            clk_3KHz      = 1'($urandom());
            self_test     = 1'($urandom());
            coin          = 1'($urandom());
            option_switch = 16'($urandom());
            addr = a; we = w; clk_en = ce; dataFromCore = 8'($urandom());
            #1;
            ws  = wr_slot(a);
            ewe = 5'b0;
            if (w && ws >= 0) ewe[ws] = 1'b1;
            check("rnd weEnBram", 32'(weEnBram), 32'(ewe));
            if (n % 8 == 0) check_bus("rnd");
            exp_go = ce && w && (a == 16'h1200);
            exp_vr = ce && w && (a == 16'h1600);
            if (ce && !w) begin
                code = rd_code(a);
                if (code >= 10) begin
                    exp_io   = io_value(code);
                    exp_kind = 10;
                end else begin
                    exp_kind = code;
                end
            end
            @(posedge clk);
            #1;
            if (exp_kind < 0) exp_rd = 8'hFF;
            else if (exp_kind == 10) exp_rd = 8'(exp_io);
            else exp_rd = dataFromBram[exp_kind];
            check("rnd dataToCore", 32'(dataToCore), 32'(exp_rd));
            check("rnd vggo", 32'(vggo), 32'(exp_go));
            check("rnd vgrst", 32'(vgrst), 32'(exp_vr));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
